mem_burst_responder: RTL and testbench

//  Main-memory-side responder for the cache's byte-serial block interface (addr_mem/data_mem/rd_mem/wr_mem/ready_mem).

---
 rtl/mem_burst_responder.sv | 169 ++++++++++++++++
 tb/tb_mem_burst_responder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_responder.sv
// mem_burst_responder
// Main-memory side of the cache's byte-serial block interface. Serves 4-byte
// line fills (reads) and line write-backs from an internal byte array, with
// programmable read and write acknowledge latency. A line write is held in a
// shift buffer and committed to the array in a single edge, so an aborted
// write never leaves a partially updated line behind.
module mem_burst_responder #(
    parameter int AWIDTH     = 9,
    parameter int DWIDTH     = 8,
    parameter int BLOCKSIZE  = 4,
    parameter int RD_LATENCY = 2,
    parameter int WR_LATENCY = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] addr_mem,
    inout  wire  [DWIDTH-1:0] data_mem,
    input  logic              rd_mem,
    input  logic              wr_mem,
    output logic              ready_mem,
    output logic              proto_err
);

    localparam int OFFW  = $clog2(BLOCKSIZE);
    localparam int DEPTH = 1 << AWIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LAT,
        S_RD_ACK,
        S_RD_BURST,
        S_WR_CAP,
        S_WR_LAT,
        S_WR_ACK
    } state_t;

    state_t                           state_q, state_d;
    logic                             req_q;
    logic                             ready_q;
    logic [AWIDTH-1:0]                base_q;
    logic [OFFW-1:0]                  beat_q;
    logic [7:0]                       lat_q;
    logic [(BLOCKSIZE-1)*DWIDTH-1:0]  wbuf_q;
    logic [DWIDTH-1:0]                mem [0:DEPTH-1];

    logic                             start;
    logic                             beat_last;
    logic                             rd_lat_last;
    logic                             wr_lat_last;
    logic                             commit;
    logic                             proto_set;
    logic                             drive_en;
    logic [BLOCKSIZE*DWIDTH-1:0]      line_w;
    logic [DWIDTH-1:0]                rd_byte;

    // The line offset bits of the address are ignored: bursts always start on a line boundary.
    logic unused_offset;
    assign unused_offset = ^addr_mem[OFFW-1:0];

    // Only a rising edge of the request level opens a transaction.
    assign start     = (rd_mem | wr_mem) & ~req_q;
    assign ready_mem = ready_q & ~start;

    // Read data comes straight from the array at base + beat; bus is released otherwise.
    assign rd_byte  = mem[base_q + AWIDTH'(beat_q)];
    assign data_mem = drive_en ? rd_byte : {DWIDTH{1'bz}};

    // Full line as seen on the last capture cycle: three buffered bytes plus the live bus byte.
    assign line_w = {data_mem, wbuf_q};

    // Next-state decode, protocol checking and commit strobe.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        beat_last   = (beat_q == OFFW'(BLOCKSIZE - 1));
        rd_lat_last = (lat_q == 8'(RD_LATENCY - 1));
        wr_lat_last = (lat_q == 8'(WR_LATENCY - 1));
        commit      = 1'b0;
        drive_en    = 1'b0;
        proto_set   = start & ((state_q != S_IDLE) | (rd_mem & wr_mem));

        case (state_q)
            S_IDLE: begin
                if (start && rd_mem && !wr_mem) begin
                    state_d = (RD_LATENCY == 0) ? S_RD_ACK : S_RD_LAT;
                end else if (start && wr_mem && !rd_mem) begin
                    state_d = S_WR_CAP;
                end
            end
            S_RD_LAT: begin
                if (rd_lat_last) state_d = S_RD_ACK;
            end
            S_RD_ACK: begin
                state_d = S_RD_BURST;
            end
            S_RD_BURST: begin
                drive_en = 1'b1;
                if (beat_last) state_d = S_IDLE;
            end
            S_WR_CAP: begin
                if (beat_last) begin
                    commit  = reset_n;
                    state_d = (WR_LATENCY == 0) ? S_WR_ACK : S_WR_LAT;
                end
            end
            S_WR_LAT: begin
                if (wr_lat_last) state_d = S_WR_ACK;
            end
            S_WR_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control state: FSM, request edge tracker, ready, base address, counters, capture buffer.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            ready_q   <= 1'b1;
            proto_err <= 1'b0;
            base_q    <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            wbuf_q    <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= rd_mem | wr_mem;
            ready_q <= (state_d == S_IDLE) || (state_d == S_RD_ACK) || (state_d == S_WR_ACK);

            if (proto_set) proto_err <= 1'b1;

            if (state_q == S_IDLE && start) begin
                base_q <= {addr_mem[AWIDTH-1:OFFW], {OFFW{1'b0}}};
            end

            if (state_d != state_q) begin
                lat_q <= '0;
            end else if (state_q == S_RD_LAT || state_q == S_WR_LAT) begin
                lat_q <= lat_q + 8'd1;
            end

            if (state_d != state_q) begin
                beat_q <= '0;
            end else if (state_q == S_RD_BURST || state_q == S_WR_CAP) begin
                beat_q <= beat_q + OFFW'(1);
            end

            if (state_q == S_WR_CAP) begin
                wbuf_q <= {data_mem, wbuf_q[(BLOCKSIZE-1)*DWIDTH-1:DWIDTH]};
            end
        end
    end

    // Array write port: the whole line lands in one edge on the final capture.
    always_ff @(posedge clock) begin
        // NOTE: the array is deliberately not reset; its contents must survive a reset.
        if (commit) begin
            for (int i = 0; i < BLOCKSIZE; i++) begin
                mem[base_q + AWIDTH'(i)] <= line_w[i*DWIDTH +: DWIDTH];
            end
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// tb_mem_burst_responder
// Directed stimulus pushes the expected response of each transaction into a
// queue; an independent monitor on the falling edge watches the handshake,
// pops the queue and compares latency, proto_err and read data.
module tb_mem_burst_responder;

    localparam int RD_LAT  = 2;
    localparam int WR_LAT  = 0;
    localparam int BUSY_RD = 1 + RD_LAT;
    localparam int BUSY_WR = 1 + 4 + WR_LAT;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [8:0] addr_mem = '0;
    logic       rd_mem = 1'b0;
    logic       wr_mem = 1'b0;
    wire  [7:0] data_mem;
    logic       ready_mem;
    logic       proto_err;

    logic       stim_en = 1'b0;
    logic [7:0] stim_data = '0;
    logic       probe_en = 1'b0;

    // Bench side of the byte bus: write data, or a zero probe to detect a stray DUT drive.
    assign data_mem = stim_en ? stim_data : (probe_en ? 8'h00 : 8'hzz);

    always #5 clock = ~clock;

    mem_burst_responder #(
        .AWIDTH(9), .DWIDTH(8), .BLOCKSIZE(4), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)
    ) dut (
        .clock(clock), .reset_n(reset_n), .addr_mem(addr_mem), .data_mem(data_mem),
        .rd_mem(rd_mem), .wr_mem(wr_mem), .ready_mem(ready_mem), .proto_err(proto_err)
    );

    typedef enum logic [1:0] {K_RD, K_WR, K_ABORT, K_PERR} kind_t;
    typedef struct packed {
        kind_t       kind;
        logic [15:0] busy;
        logic        perr;
        logic [31:0] line;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_perr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    typedef enum {M_IDLE, M_BUSY, M_DATA, M_REL, M_POSTRST, M_PERR} mstate_t;
    mstate_t ms = M_IDLE;
    exp_t    cur = '0;
    int      cnt = 0;
    int      k = 0;
    logic    prev_req = 1'b0;

    always @(negedge clock) begin
        if (!reset_n) begin
            if (ms != M_IDLE && ms != M_POSTRST && cur.kind != K_ABORT) begin
                checks++;
                errors++;
                $display("FAIL unexpected_reset: transaction in progress (t=%0t)", $time);
            end
            ms       = M_POSTRST;
            probe_en = 1'b1;
            prev_req = 1'b0;
        end else begin
            case (ms)
                M_POSTRST: begin
                    check("reset_ready", ready_mem, 1);
                    check("reset_proto_err", proto_err, 0);
                    check("reset_bus_released", data_mem, 8'h00);
                    probe_en = 1'b0;
                    ms = M_IDLE;
                end
                M_IDLE: begin
                    if ((rd_mem | wr_mem) && !prev_req) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_request: scoreboard empty (t=%0t)", $time);
                        end else begin
                            cur = sb.pop_front();
                            check("start_ready_low", ready_mem, 0);
                            if (cur.kind == K_PERR) begin
                                ms = M_PERR;
                            end else begin
                                cnt = 1;
                                ms  = M_BUSY;
                            end
                        end
                    end
                end
                M_PERR: begin
                    check("perr_flag", proto_err, 1);
                    check("perr_stays_idle", ready_mem, 1);
                    ms = M_IDLE;
                end
                M_BUSY: begin
                    if (!ready_mem) begin
                        cnt++;
                        if (cnt > 600) begin
                            checks++;
                            errors++;
                            $display("FAIL ack_timeout: no ack after %0d cycles (t=%0t)", cnt, $time);
                            ms = M_IDLE;
                        end
                    end else begin
                        check(cur.kind == K_RD ? "rd_busy_cycles" : "wr_busy_cycles", cnt, cur.busy);
                        check("ack_proto_err", proto_err, cur.perr);
                        if (cur.kind == K_RD) begin
                            k  = 0;
                            ms = M_DATA;
                        end else begin
                            ms = M_IDLE;
                        end
                    end
                end
                M_DATA: begin
                    check($sformatf("rd_byte%0d", k), data_mem, cur.line[k*8 +: 8]);
                    k++;
                    if (k == 4) begin
                        probe_en = 1'b1;
                        ms = M_REL;
                    end
                end
                M_REL: begin
                    check("post_burst_bus_released", data_mem, 8'h00);
                    check("post_burst_ready", ready_mem, 1);
                    probe_en = 1'b0;
                    ms = M_IDLE;
                end
                default: ms = M_IDLE;
            endcase
            prev_req = rd_mem | wr_mem;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (ready_mem) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL stim_wait_ready: timed out (t=%0t)", $time);
        end
    endtask

    task automatic do_write(input logic [8:0] a, input logic [31:0] line);
        sb.push_back('{kind: K_WR, busy: 16'(BUSY_WR), perr: exp_perr, line: line});
        tick();
        addr_mem = a;
        wr_mem   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            stim_en   = 1'b1;
            stim_data = line[i*8 +: 8];
        end
        tick();
        stim_en = 1'b0;
        wait_ready();
        tick();
        wr_mem = 1'b0;
        tick();
    endtask

    task automatic do_read(input logic [8:0] a, input logic [31:0] line);
        sb.push_back('{kind: K_RD, busy: 16'(BUSY_RD), perr: exp_perr, line: line});
        tick();
        addr_mem = a;
        rd_mem   = 1'b1;
        tick();
        wait_ready();
        tick();
        rd_mem = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        // T1: reset held for two clocks.
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // T2: line write at 0x0A7 (base 0x0A4), plus a neighbouring line.
        do_write(9'h0A7, 32'h44332211);
        do_write(9'h0A8, 32'h88776655);

        // T3: read from an unaligned address within the line.
        do_read(9'h0A5, 32'h44332211);
        do_read(9'h0AB, 32'h88776655);

        // T4: top-of-array line must not wrap into address 0.
        do_write(9'h000, 32'h04030201);
        do_write(9'h1FF, 32'hD4C3B2A1);
        do_read(9'h1FF, 32'hD4C3B2A1);
        do_read(9'h1FC, 32'hD4C3B2A1);
        do_read(9'h000, 32'h04030201);

        // T5: reset after the second captured write byte; array must be unchanged.
        sb.push_back('{kind: K_ABORT, busy: 16'd0, perr: 1'b0, line: 32'h0});
        tick();
        addr_mem = 9'h0A6;
        wr_mem   = 1'b1;
        tick();
        stim_en   = 1'b1;
        stim_data = 8'hEE;
        tick();
        stim_data = 8'hDD;
        tick();
        reset_n = 1'b0;
        wr_mem  = 1'b0;
        stim_en = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (2) tick();
        do_read(9'h0A4, 32'h44332211);

        // T6: read and write rising together.
        sb.push_back('{kind: K_PERR, busy: 16'd0, perr: 1'b1, line: 32'h0});
        exp_perr = 1'b1;
        tick();
        addr_mem = 9'h0A4;
        rd_mem   = 1'b1;
        wr_mem   = 1'b1;
        tick();
        tick();
        rd_mem = 1'b0;
        wr_mem = 1'b0;
        tick();
        do_read(9'h0A4, 32'h44332211);
        do_read(9'h0A8, 32'h88776655);

        repeat (4) tick();
        check("scoreboard_drained", sb.size(), 0);
        check("monitor_idle", (ms == M_IDLE) ? 1 : 0, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
        $fatal(1);
    end

endmodule
